// File: rtl/stft_pkg.sv
// Shared types and sizing helpers for the STFT sample scheduler and bin framer.
package stft_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE     = 2'd0;
    localparam sched_state_t ST_ALT_WAIT = 2'd1;
    localparam sched_state_t ST_ALT_NOW  = 2'd2;

    // Width of a bin index covering 0..fft_size/2 inclusive.
    function automatic int bin_idx_w(input int fft_size);
        return $clog2(fft_size / 2 + 1);
    endfunction

endpackage

// File: rtl/stft_bin_framer.sv
// Tracks the FFT output stream and emits the non-redundant bins 0..FFT_SIZE/2
// of each frame, tagged with index, frame-last flag and a completed-frame count.
module stft_bin_framer
    import stft_pkg::*;
#(
    parameter int OW       = 18,
    parameter int FFT_SIZE = 256
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_fft_ce,
    input  logic                               i_fft_sync,
    input  logic [2*OW-1:0]                    i_fft_result,
    output logic                               o_bin_valid,
    output logic [bin_idx_w(FFT_SIZE)-1:0]     o_bin_idx,
    output logic [2*OW-1:0]                    o_bin_data,
    output logic                               o_frame_last,
    output logic [FRAME_CNT_W-1:0]             o_frame_count
);

    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int BIN_W = bin_idx_w(FFT_SIZE);
    localparam logic [IDX_W-1:0] HALF = IDX_W'(FFT_SIZE / 2);

    logic                   synced_q, synced_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       cur_idx;
    logic                   valid_q, valid_d;
    logic [BIN_W-1:0]       bin_idx_q, bin_idx_d;
    logic [2*OW-1:0]        data_q, data_d;
    logic                   last_q, last_d;
    logic [FRAME_CNT_W-1:0] count_q, count_d;

    // idx_q holds the index the next FFT beat will carry; a sync beat is bin 0.
    always_comb begin
        synced_d  = synced_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        bin_idx_d = bin_idx_q;
        data_d    = data_q;
        count_d   = count_q;
        cur_idx   = i_fft_sync ? '0 : idx_q;
        if (i_fft_ce) begin
            if (i_fft_sync) begin
                synced_d = 1'b1;
            end
            idx_d = cur_idx + IDX_W'(1);
            if ((synced_q || i_fft_sync) && (cur_idx <= HALF)) begin
                valid_d   = 1'b1;
                bin_idx_d = BIN_W'(cur_idx);
                data_d    = i_fft_result;
                if (cur_idx == HALF) begin
                    last_d  = 1'b1;
                    count_d = count_q + FRAME_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            synced_q  <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            bin_idx_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            synced_q  <= synced_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            bin_idx_q <= bin_idx_d;
            data_q    <= data_d;
            last_q    <= last_d;
            count_q   <= count_d;
        end
    end

    assign o_bin_valid   = valid_q;
    assign o_bin_idx     = bin_idx_q;
    assign o_bin_data    = data_q;
    assign o_frame_last  = last_q;
    assign o_frame_count = count_q;

endmodule

// File: rtl/stft_sched.sv
// STFT front scheduler: turns the audio sample strobe into the o_ce/o_alt_ce
// pair for the 50%-overlap window, and frames the FFT output into bins.
module stft_sched
    import stft_pkg::*;
#(
    parameter int IW        = 16,
    parameter int OW        = 18,
    parameter int FFT_SIZE  = 256,
    parameter int ALT_DELAY = 4
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_sample_valid,
    input  logic [IW-1:0]                      i_sample,
    output logic                               o_ce,
    output logic                               o_alt_ce,
    output logic [IW-1:0]                      o_sample,
    input  logic                               i_fft_ce,
    input  logic                               i_fft_sync,
    input  logic [2*OW-1:0]                    i_fft_result,
    output logic                               o_bin_valid,
    output logic [bin_idx_w(FFT_SIZE)-1:0]     o_bin_idx,
    output logic [2*OW-1:0]                    o_bin_data,
    output logic                               o_frame_last,
    output logic [FRAME_CNT_W-1:0]             o_frame_count,
    output logic                               o_overrun,
    output logic                               o_drop,
    output sched_state_t                       o_sched_state
);

    localparam logic [3:0] ALT_LOAD = 4'(ALT_DELAY - 1);

    sched_state_t  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          skid_full_q, skid_full_d;
    logic [IW-1:0] skid_q, skid_d;
    logic          ce_q, ce_d;
    logic          alt_q, alt_d;
    logic [IW-1:0] sample_q, sample_d;
    logic          overrun_q, overrun_d;
    logic          drop_q, drop_d;

    // An early sample forces the alt pass out immediately, then replays from the skid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        ce_d        = 1'b0;
        alt_d       = 1'b0;
        sample_d    = sample_q;
        overrun_d   = 1'b0;
        drop_d      = i_sample_valid && skid_full_q;
        case (state_q)
            ST_IDLE: begin
                if (i_sample_valid) begin
                    ce_d     = 1'b1;
                    sample_d = i_sample;
                    cnt_d    = ALT_LOAD;
                    state_d  = ST_ALT_WAIT;
                end
            end
            ST_ALT_WAIT: begin
                if (i_sample_valid && !skid_full_q) begin
                    skid_d      = i_sample;
                    skid_full_d = 1'b1;
                    overrun_d   = 1'b1;
                    alt_d       = 1'b1;
                    state_d     = ST_ALT_NOW;
                end else if (cnt_q == 4'd0) begin
                    alt_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ALT_NOW: begin
                ce_d        = 1'b1;
                sample_d    = skid_q;
                skid_full_d = 1'b0;
                cnt_d       = ALT_LOAD;
                state_d     = ST_ALT_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            ce_q        <= 1'b0;
            alt_q       <= 1'b0;
            sample_q    <= '0;
            overrun_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            ce_q        <= ce_d;
            alt_q       <= alt_d;
            sample_q    <= sample_d;
            overrun_q   <= overrun_d;
            drop_q      <= drop_d;
        end
    end

    assign o_ce          = ce_q;
    assign o_alt_ce      = alt_q;
    assign o_sample      = sample_q;
    assign o_overrun     = overrun_q;
    assign o_drop        = drop_q;
    assign o_sched_state = state_q;

    stft_bin_framer #(
        .OW       (OW),
        .FFT_SIZE (FFT_SIZE)
    ) u_framer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_fft_ce      (i_fft_ce),
        .i_fft_sync    (i_fft_sync),
        .i_fft_result  (i_fft_result),
        .o_bin_valid   (o_bin_valid),
        .o_bin_idx     (o_bin_idx),
        .o_bin_data    (o_bin_data),
        .o_frame_last  (o_frame_last),
        .o_frame_count (o_frame_count)
    );

endmodule

// File: tb/tb_stft_sched.sv
// Directed bench for stft_sched: scheduler nominal/overrun/drop/reset paths
// and bin framing with FFT_SIZE=8.
module tb_stft_sched;
    import stft_pkg::*;

    localparam int IW        = 16;
    localparam int OW        = 18;
    localparam int FFT_SIZE  = 8;
    localparam int ALT_DELAY = 4;
    localparam int BW        = bin_idx_w(FFT_SIZE);

    logic                   clk = 1'b0;
    logic                   i_reset;
    logic                   i_sample_valid;
    logic [IW-1:0]          i_sample;
    logic                   o_ce;
    logic                   o_alt_ce;
    logic [IW-1:0]          o_sample;
    logic                   i_fft_ce;
    logic                   i_fft_sync;
    logic [2*OW-1:0]        i_fft_result;
    logic                   o_bin_valid;
    logic [BW-1:0]          o_bin_idx;
    logic [2*OW-1:0]        o_bin_data;
    logic                   o_frame_last;
    logic [FRAME_CNT_W-1:0] o_frame_count;
    logic                   o_overrun;
    logic                   o_drop;
    sched_state_t           o_sched_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stft_sched #(
        .IW        (IW),
        .OW        (OW),
        .FFT_SIZE  (FFT_SIZE),
        .ALT_DELAY (ALT_DELAY)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .o_ce           (o_ce),
        .o_alt_ce       (o_alt_ce),
        .o_sample       (o_sample),
        .i_fft_ce       (i_fft_ce),
        .i_fft_sync     (i_fft_sync),
        .i_fft_result   (i_fft_result),
        .o_bin_valid    (o_bin_valid),
        .o_bin_idx      (o_bin_idx),
        .o_bin_data     (o_bin_data),
        .o_frame_last   (o_frame_last),
        .o_frame_count  (o_frame_count),
        .o_overrun      (o_overrun),
        .o_drop         (o_drop),
        .o_sched_state  (o_sched_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [IW-1:0] s);
        i_sample_valid = 1'b1;
        i_sample       = s;
        tick();
        i_sample_valid = 1'b0;
    endtask

    // Strobe vector order: {o_ce, o_alt_ce, o_overrun, o_drop}
    task automatic expect_strobes(input string tag, input logic [3:0] exp);
        check(tag, {o_ce, o_alt_ce, o_overrun, o_drop}, exp);
    endtask

    task automatic idle_strobes(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_strobes(tag, 4'b0000);
        end
    endtask

    task automatic fft_step(input string tag, input logic ce, input logic sync,
                            input logic [2*OW-1:0] res, input logic ev,
                            input logic [BW-1:0] eidx, input logic elast,
                            input logic [15:0] ecount);
        i_fft_ce     = ce;
        i_fft_sync   = sync;
        i_fft_result = res;
        tick();
        i_fft_ce     = 1'b0;
        i_fft_sync   = 1'b0;
        check({tag, "_valid"}, o_bin_valid, ev);
        if (ev) begin
            check({tag, "_idx"}, o_bin_idx, eidx);
            check({tag, "_data"}, o_bin_data, res);
            check({tag, "_last"}, o_frame_last, elast);
        end
        check({tag, "_count"}, o_frame_count, ecount);
    endtask

    initial begin
        i_reset        = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_fft_ce       = 1'b0;
        i_fft_sync     = 1'b0;
        i_fft_result   = '0;
        tick();
        tick();

        expect_strobes("rst_strobes", 4'b0000);
        check("rst_sample", o_sample, 16'h0);
        check("rst_bin_valid", o_bin_valid, 1'b0);
        check("rst_bin_idx", o_bin_idx, '0);
        check("rst_bin_data", o_bin_data, '0);
        check("rst_frame_last", o_frame_last, 1'b0);
        check("rst_frame_count", o_frame_count, 16'd0);
        check("rst_state", o_sched_state, ST_IDLE);
        i_reset = 1'b0;
        tick();

        // Single sample, nominal path: o_ce at t+1, o_alt_ce at t+5
        drive_sample(16'h1234);
        expect_strobes("single_ce", 4'b1000);
        check("single_sample", o_sample, 16'h1234);
        idle_strobes("single_gap", 3);
        tick();
        expect_strobes("single_alt", 4'b0100);
        tick();
        expect_strobes("single_after", 4'b0000);
        check("single_state_idle", o_sched_state, ST_IDLE);

        // Overrun on an early second sample, drop while the skid is full
        drive_sample(16'hAAAA);
        expect_strobes("ovr_ce1", 4'b1000);
        check("ovr_sample1", o_sample, 16'hAAAA);
        tick();
        expect_strobes("ovr_gap1", 4'b0000);
        drive_sample(16'hBBBB);
        expect_strobes("ovr_alt_overrun", 4'b0110);
        check("ovr_state_alt_now", o_sched_state, ST_ALT_NOW);
        drive_sample(16'hCCCC);
        expect_strobes("ovr_ce2_drop", 4'b1001);
        check("ovr_sample2", o_sample, 16'hBBBB);
        idle_strobes("ovr_gap2", 3);
        tick();
        expect_strobes("ovr_alt2", 4'b0100);
        tick();
        expect_strobes("ovr_after", 4'b0000);
        check("ovr_state_idle", o_sched_state, ST_IDLE);
        check("ovr_no_dropped_sample", o_sample, 16'hBBBB);

        // Reset with the skid full abandons the pending alt and skid sample
        drive_sample(16'h1111);
        expect_strobes("rm_ce1", 4'b1000);
        tick();
        drive_sample(16'h2222);
        expect_strobes("rm_overrun", 4'b0110);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        expect_strobes("rm_reset_quiet", 4'b0000);
        check("rm_state", o_sched_state, ST_IDLE);
        check("rm_sample_cleared", o_sample, 16'h0);
        tick();
        expect_strobes("rm_post_quiet", 4'b0000);
        drive_sample(16'h5555);
        expect_strobes("rm_ce", 4'b1000);
        check("rm_sample", o_sample, 16'h5555);
        idle_strobes("rm_gap", 3);
        tick();
        expect_strobes("rm_alt", 4'b0100);
        tick();
        expect_strobes("rm_after", 4'b0000);

        // Framer: beats before any sync are ignored
        for (int k = 0; k < 5; k++)
            fft_step("presync", 1'b1, 1'b0, 36'(k + 1), 1'b0, '0, 1'b0, 16'd0);

        // Synced frame, result=k on bin k; only bins 0..4 emitted
        for (int k = 0; k < 8; k++)
            fft_step("frame1", 1'b1, (k == 0), 36'(k), (k <= 4), BW'(k), (k == 4),
                     (k >= 4) ? 16'd1 : 16'd0);

        fft_step("gap_no_ce", 1'b0, 1'b0, 36'h0, 1'b0, '0, 1'b0, 16'd1);

        // Mid-frame resync at idx 3 aborts the frame without counting it
        fft_step("f2_idx0", 1'b1, 1'b1, 36'hABCDEF012, 1'b1, 3'd0, 1'b0, 16'd1);
        fft_step("f2_idx1", 1'b1, 1'b0, 36'h1, 1'b1, 3'd1, 1'b0, 16'd1);
        fft_step("f2_idx2", 1'b1, 1'b0, 36'h2, 1'b1, 3'd2, 1'b0, 16'd1);
        fft_step("resync", 1'b1, 1'b1, 36'h3F, 1'b1, 3'd0, 1'b0, 16'd1);
        for (int k = 1; k <= 4; k++)
            fft_step("f3", 1'b1, 1'b0, 36'(k + 16), 1'b1, BW'(k), (k == 4),
                     (k == 4) ? 16'd2 : 16'd1);
        for (int k = 5; k < 8; k++)
            fft_step("f3_upper", 1'b1, 1'b0, 36'(k + 16), 1'b0, '0, 1'b0, 16'd2);

        // Reset clears synced: framer waits for a fresh sync
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("fr_rst_count", o_frame_count, 16'd0);
        check("fr_rst_valid", o_bin_valid, 1'b0);
        fft_step("post_rst_nosync", 1'b1, 1'b0, 36'h7, 1'b0, '0, 1'b0, 16'd0);
        fft_step("post_rst_nosync", 1'b1, 1'b0, 36'h8, 1'b0, '0, 1'b0, 16'd0);
        fft_step("post_rst_sync", 1'b1, 1'b1, 36'h9, 1'b1, 3'd0, 1'b0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stft_sched.md
# stft_sched

Sample-rate scheduler and bin framer for the STFT datapath. Turns the sparse audio-sample strobe into the `i_ce`/`i_alt_ce` pair that the 50%-overlap window function needs, and tracks the FFT output stream. From that stream it emits only the non-redundant bins 0..FFT_SIZE/2 of each real-input frame, each tagged with its index and with frame boundaries. It sits between the audio front end, `windowfn`/`fftmain`, and the downstream feature stage.

## Interface

Parameters:
- `IW`, 16: input sample width.
- `OW`, 18: FFT output component width; a bin is 2*OW bits, {re, im}.
- `FFT_SIZE`, 256: FFT length, power of two, 8..4096.
- `ALT_DELAY`, 4: cycles from `o_ce` to `o_alt_ce`, range 1..15.

Ports:
- `i_clk`, in, 1: single clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_sample_valid`, in, 1: one-cycle strobe, a new audio sample is present.
- `i_sample`, in, IW: audio sample, qualified by `i_sample_valid`.
- `o_ce`, out, 1: sample write strobe to window.
- `o_alt_ce`, out, 1: overlap (second-pass) strobe to window.
- `o_sample`, out, IW: sample to window, valid with `o_ce`.
- `i_fft_ce`, in, 1: the CE driving `fftmain`, i.e. window `o_ce`.
- `i_fft_sync`, in, 1: FFT `o_sync`, which marks bin 0.
- `i_fft_result`, in, 2*OW: FFT `o_result`.
- `o_bin_valid`, out, 1: bin output strobe.
- `o_bin_idx`, out, $clog2(FFT_SIZE/2+1): bin index.
- `o_bin_data`, out, 2*OW: bin value.
- `o_frame_last`, out, 1: asserted with bin FFT_SIZE/2.
- `o_frame_count`, out, 16: completed frames, wraps at 2^16.
- `o_overrun`, out, 1: one-cycle pulse, a sample arrived while the alt strobe was still pending.
- `o_drop`, out, 1: one-cycle pulse, a sample was discarded.

## Operation

Input scheduler FSM, states IDLE, ALT_WAIT, ALT_NOW:
- IDLE + `i_sample_valid`: next cycle `o_ce`=1 and `o_sample`=`i_sample`; load the delay counter with ALT_DELAY-1; go to ALT_WAIT.
- ALT_WAIT: decrement the counter each cycle. At 0, assert `o_alt_ce` the next cycle and return to IDLE.
- ALT_WAIT + `i_sample_valid`, skid register empty:
  - latch the sample into the one-entry skid register;
  - pulse `o_overrun`;
  - go to ALT_NOW.
- ALT_NOW: next cycle `o_alt_ce`=1. The cycle after, `o_ce`=1 with the skid sample; clear the skid; reload the counter; go to ALT_WAIT.
- Any `i_sample_valid` while the skid is full: sample discarded, `o_drop` pulses, state unchanged.
- Exactly one `o_alt_ce` lies between consecutive `o_ce` pulses. `o_ce` and `o_alt_ce` are never high together.

Bin framer:
- `synced` clears on reset. It sets on a cycle with `i_fft_ce` && `i_fft_sync`, which also sets idx=0.
- Each subsequent `i_fft_ce` increments idx, wrapping at FFT_SIZE. A sync mid-frame forces idx=0 (resynchronization).
- A bin is emitted when `synced` && `i_fft_ce` && idx <= FFT_SIZE/2. Indices FFT_SIZE/2+1..FFT_SIZE-1 are suppressed.
- `o_frame_last` accompanies idx == FFT_SIZE/2. `o_frame_count` increments on the same cycle `o_frame_last` is issued.
- Results before the first sync are ignored.

## Timing

- All outputs are registered. Reset values: every strobe 0, `o_sample` 0, `o_bin_*` 0, `o_frame_count` 0, FSM IDLE, skid empty, `synced` 0.
- `i_sample_valid` to `o_ce`: 1 cycle.
- `o_ce` to `o_alt_ce`: ALT_DELAY cycles, nominal path.
- Overrun path: `o_alt_ce` 1 cycle after the offending strobe, then `o_ce` 1 cycle after that.
- `i_fft_ce` to `o_bin_valid`: 1 cycle.
- Reset mid-operation: the next cycle all strobes are 0, any pending alt and skid sample are abandoned, and `synced` clears. The framer waits for a fresh sync.
- `i_fft_ce` with the same-cycle sync takes priority over increment.

## Structure

- Shared package `stft_pkg`:
  - scheduler state enum;
  - `BIN_IDX_W` = $clog2(FFT_SIZE/2+1) as a function/localparam;
  - `FRAME_CNT_W`=16.
- Optional sub-module `stft_bin_framer` for the FFT-side counter and emit logic; the scheduler FSM stays in the top.
- Expected size: about 200 RTL lines.

## Test plan

- Single sample 0x1234, ALT_DELAY=4: `o_ce` at t+1 with `o_sample`=0x1234, `o_alt_ce` at t+5, no other strobes, FSM back in IDLE.
- Samples every 2 cycles, ALT_DELAY=4:
  - second sample pulses `o_overrun` and yields `o_alt_ce` then `o_ce`;
  - a third sample arriving with the skid full pulses `o_drop` and never appears on `o_sample`.
- FFT_SIZE=8, sync plus 8 continuous `i_fft_ce` with result=k on bin k:
  - `o_bin_valid` for idx 0..4 only, data 0..4;
  - `o_frame_last` at idx 4;
  - `o_frame_count` 0→1.
- 5 `i_fft_ce` before any sync: no `o_bin_valid`. Then sync: idx starts at 0.
- Sync injected at idx 3 mid-frame: idx restarts at 0 and `o_frame_count` does not increment for the aborted frame.
- Reset asserted while ALT_WAIT with the skid full: the next cycle there are no strobes, and the subsequent `i_sample_valid` produces a normal nominal-path `o_ce`/`o_alt_ce` pair.
